// File: rtl/seq_divider_8bit_if.sv
// Start/done handshake bundle for the sequential divider: operands in, quotient and
// remainder out.
interface seq_divider_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Iterative restoring unsigned divider: one trial subtraction per clock, WIDTH clocks per
// quotient. Divide-by-zero completes in a single clock with saturated quotient.
module seq_divider_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  seq_divider_8bit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  // The restored partial remainder is always below D, so its top bit is never stored.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    trial  = {r_q, q_q[WIDTH-1]};
    diff   = trial - {1'b0, d_q};
    r_next = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = StRun;
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            r_d     = '0;
            count_d = '0;
          end
        end
      end
      StRun: begin
        r_d     = r_next;
        q_d     = q_next;
        count_d = count_q + CntW'(1);
        if (count_q == LastCount) begin
          state_d     = StDone;
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Both flags decode the state register, so they can never overlap.
  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed and reference-checked bench for seq_divider_8bit; inputs driven and outputs
// sampled on the falling edge.
module tb_seq_divider_8bit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  seq_divider_8bit_if #(.WIDTH(8)) bus ();

  seq_divider_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // lat counts falling edges from the start-driving edge until done is seen:
  // 9 for a normal op (done after WIDTH edges past capture), 1 for divide-by-zero.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                       output int busy_cycles, output logic [7:0] q, output logic [7:0] r,
                       output logic dz);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start   = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
      fails++;
      $display("FAIL reset_asserted: got %h, required 0",
               {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %h, required 0", i,
                 {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder});
      end
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [7:0] q, r;
    logic dz;
    do_op(8'd200, 8'd7, lat, bc, q, r, dz);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL basic_latency: got %0d, required 9", lat); end
    tests++;
    if (bc !== 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d, required 8", bc); end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("FAIL basic_busy_with_done: got %b, required 0", bus.busy);
    end
    tests++;
    if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
      fails++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b, required q=28 r=4 dz=0", q, r, dz);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.done, bus.busy, bus.quotient, bus.remainder} !== {2'b00, 8'd28, 8'd4}) begin
        fails++;
        $display("FAIL basic_hold %0d: got done=%b busy=%b q=%0d r=%0d, required 0 0 28 4", i,
                 bus.done, bus.busy, bus.quotient, bus.remainder);
      end
    end
  endtask

  task automatic test_edges();
    logic [7:0] ta [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
    logic [7:0] tb [4] = '{8'd1, 8'd255, 8'd9, 8'd3};
    logic [7:0] tq [4] = '{8'd255, 8'd1, 8'd0, 8'd0};
    logic [7:0] tr [4] = '{8'd0, 8'd0, 8'd5, 8'd0};
    int lat, bc;
    logic [7:0] q, r;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], lat, bc, q, r, dz);
      tests++;
      if ({q, r, dz} !== {tq[i], tr[i], 1'b0} || lat !== 9) begin
        fails++;
        $display("FAIL edge %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d dz=0 lat=9",
                 ta[i], tb[i], q, r, dz, lat, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    logic [7:0] q, r;
    logic dz;
    do_op(8'd100, 8'd0, lat, bc, q, r, dz);
    tests++;
    if (lat !== 1 || bc !== 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d busy=%b, required 1 0 0",
               lat, bc, bus.busy);
    end
    tests++;
    if ({q, r, dz} !== {8'd255, 8'd100, 1'b1}) begin
      fails++; $display("FAIL dbz_result: got q=%0d r=%0d dz=%b, required 255 100 1", q, r, dz);
    end
    do_op(8'd100, 8'd10, lat, bc, q, r, dz);
    tests++;
    if ({q, r, dz} !== {8'd10, 8'd0, 1'b0} || lat !== 9) begin
      fails++;
      $display("FAIL dbz_recover: got q=%0d r=%0d dz=%b lat=%0d, required 10 0 0 9", q, r, dz, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    bus.start    = 1'b1;
    bus.dividend = 8'd10;
    bus.divisor  = 8'd3;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    tests++;
    if ({bus.quotient, bus.remainder} !== {8'd28, 8'd4} || lat !== 9) begin
      fails++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, required 28 4 9",
               bus.quotient, bus.remainder, lat);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [7:0] q, r;
    logic dz;
    do_op(8'd50, 8'd7, lat, bc, q, r, dz);
    tests++;
    if ({q, r} !== {8'd7, 8'd1}) begin
      fails++; $display("FAIL b2b_first: got q=%0d r=%0d, required 7 1", q, r);
    end
    // Still in the DONE cycle: issue the next op without a gap.
    bus.start    = 1'b1;
    bus.dividend = 8'd81;
    bus.divisor  = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    tests++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd9, 8'd0, 1'b0} || lat !== 9) begin
      fails++;
      $display("FAIL b2b_second: got q=%0d r=%0d dz=%b lat=%0d, required 9 0 0 9",
               bus.quotient, bus.remainder, bus.div_by_zero, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid_run: got %h, required 0",
               {bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++; $display("FAIL reset_no_done: got activity after abort, required none");
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] q, r, a, b;
    logic dz;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      do_op(a, b, lat, bc, q, r, dz);
      tests++;
      if (q !== a / b || r !== a % b || dz !== 1'b0 || lat !== 9) begin
        fails++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d, required q=%0d r=%0d 0 9",
                 a, b, q, r, dz, lat, a / b, a % b);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
